instr_mem_ml: RTL and testbench
===============================

# instr_mem_ml

Parametrised multi-port instruction memory with a built-in streaming loader and a sequential clear engine. It serves `PORTS` cores from one program store. A handshaked loader writes program words to consecutive addresses. After reset, or on request, the store is cleared one word per cycle rather than in a single cycle. It sits between the programming front-end (wishbone/logic-analyser bridge) and the core array.

## Interface
- `DEPTH`, 128: number of instruction words; any value from 2 to 2^`PC_WIDTH`.
- `PORTS`, 2: number of independent read ports, one per core.
- `REG_READ`, 0: 0 gives combinational read data; 1 gives read data registered one cycle.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_addr` in `PORTS`*`PC_WIDTH`: read addresses, port p at bits [p*`PC_WIDTH` +: `PC_WIDTH`].
- `rd_data` out `PORTS`*`INSTR_WIDTH`: read data, packed the same way as `rd_addr`.
- `clr_req` in 1: pulse requesting a full clear.
- `ld_start` in 1: pulse starting a load burst.
- `ld_base` in `PC_WIDTH`: first write address, sampled on `ld_start`.
- `ld_count` in `PC_WIDTH`+1: number of words to write, sampled on `ld_start`.
- `ld_valid` in 1: `ld_data` holds a word.
- `ld_data` in `INSTR_WIDTH`: word to write.
- `ld_ready` out 1: loader accepts a word this cycle.
- `ld_done` out 1: one-cycle pulse when a burst completes.
- `busy` out 1: high in the CLEAR and LOAD states.

## Operation
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes zero to `mem[clr_ptr]` each cycle; `clr_ptr` runs from 0 to DEPTH-1.
  - After the write to DEPTH-1, moves to IDLE.
- IDLE:
  - `clr_req` moves to CLEAR with `clr_ptr`=0.
  - Otherwise, `ld_start` moves to LOAD.
  - `clr_req` wins when both are asserted.
- LOAD:
  - On entry, `wptr` = `ld_base`, or 0 if `ld_base` >= DEPTH; `remaining` = `ld_count`.
  - `ld_ready`=1 throughout LOAD.
  - Each cycle with `ld_valid`: writes `mem[wptr]`=`ld_data`, then `wptr` advances (DEPTH-1 wraps to 0) and `remaining` decrements.
  - The accepted word that brings `remaining` to 0 also pulses `ld_done` the next cycle and returns the FSM to IDLE.
  - `clr_req` in LOAD aborts the burst: moves to CLEAR and no `ld_done` is issued.
- `ld_start` with `ld_count`=0: FSM goes to LOAD, immediately returns to IDLE, and `ld_done` pulses with no write.
- `ld_start` outside IDLE is ignored. `ld_count` > DEPTH wraps and overwrites earlier words.
- Reads:
  - Read ports are fully independent; each returns `mem[rd_addr]`.
  - `rd_addr` >= DEPTH returns zero.
  - While in CLEAR, all `rd_data` are forced to zero, so cores fetch NOPs.
- Read and write to the same address in the same cycle return the old word (read-before-write) in both `REG_READ` modes.

## Timing
- On `rst`: FSM goes to CLEAR with `clr_ptr`=0.
  - `busy`=1, `ld_ready`=0, `ld_done`=0.
  - Registered `rd_data` (`REG_READ`=1) = 0.
  - Memory contents are not reset directly; they are cleared by the walk.
- `rst` mid-LOAD or mid-CLEAR restarts the clear from address 0.
- Clear takes exactly DEPTH cycles from `rst` deassertion to `busy`=0.
- Write latency: a word accepted at edge N is readable combinationally in cycle N+1.
- Read latency: 0 cycles (`REG_READ`=0) or 1 cycle (`REG_READ`=1).
- `ld_done` is asserted for exactly 1 cycle; `busy` falls in the same cycle.
- Handshake: a transfer occurs on an edge where `ld_valid` && `ld_ready`. `ld_data` need not be held when `ld_ready`=0.

## Configuration
- `INSTR_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed at write time; cleared words carry parity 0.
  - Adds output `par_err` [`PORTS`-1:0]: high when the read word's parity mismatches.
  - `par_err` has the same latency as `rd_data` and is forced to 0 in CLEAR and for out-of-range addresses.
- `INSTR_MEM_PARITY_EN` undefined: no parity storage and no `par_err` port.

## Structure
- `PC_WIDTH` and `INSTR_WIDTH` come from the shared defines header.
- Add FSM state encodings `IM_CLEAR`, `IM_IDLE` and `IM_LOAD` to that header.
- One sub-module, `instr_mem_loader`: it holds the FSM, `clr_ptr`, `wptr` and `remaining`, and drives write enable, address and data.
- `instr_mem_ml` holds the storage array, the per-port read muxes and the optional parity logic.

## Test plan
- Reset: deassert `rst` with DEPTH=128 → `busy`=1 for 128 cycles; all `rd_data`=0 during and after.
- Burst with wrap: `ld_base`=126, `ld_count`=4, words A,B,C,D with gaps in `ld_valid` → `mem[126]`=A, `mem[127]`=B, `mem[0]`=C, `mem[1]`=D; `ld_done` pulses once after D.
- Zero-length load and ignored start:
  - `ld_count`=0 → `ld_done` pulses with no write.
  - `ld_start` during CLEAR → ignored.
- Abort: `clr_req` after 2 of 5 words → no `ld_done`; 128-cycle clear follows; all reads 0.
- Same-cycle read/write: port 1 reads address 5 while 0xABCD is written there → old word in that cycle, 0xABCD the next, for `REG_READ`=0 and 1.
- Parity (macro defined): force-flip a stored bit → `par_err` for the reading port rises with `rd_data` latency; other ports stay 0.

Source files
------------

// File: rtl/instr_mem_ml_pkg.sv
// Shared widths, FSM state encodings and the write-port payload for the
// instruction memory and its loader.
package instr_mem_ml_pkg;

    localparam int unsigned PC_WIDTH    = 8;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IM_CLEAR = 2'd0,
        IM_IDLE  = 2'd1,
        IM_LOAD  = 2'd2
    } im_state_e;

    typedef struct packed {
        logic                   en;
        logic [PC_WIDTH-1:0]    addr;
        logic [INSTR_WIDTH-1:0] data;
    } im_wr_t;

    // Even-parity bit: makes the total number of ones in {par, word} even.
    function automatic logic even_parity(input logic [INSTR_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Loader/clear engine: owns the CLEAR/IDLE/LOAD FSM, the clear pointer, the
// load write pointer and the remaining-word count, and drives the single
// write port of the instruction store.
module instr_mem_loader
    import instr_mem_ml_pkg::*;
#(
    parameter int unsigned DEPTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    input  logic                   ld_start,
    input  logic [PC_WIDTH-1:0]    ld_base,
    input  logic [PC_WIDTH:0]      ld_count,
    input  logic                   ld_valid,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   ld_ready,
    output logic                   ld_done,
    output logic                   busy,
    output logic                   clearing_c,
    output im_wr_t                 wr_c
);

    localparam int unsigned         CW        = PC_WIDTH + 1;
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = PC_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]       DEPTH_EXT = CW'(DEPTH);

    im_state_e           state, state_next;
    logic [PC_WIDTH-1:0] clr_ptr, clr_ptr_next;
    logic [PC_WIDTH-1:0] wptr, wptr_next;
    logic [CW-1:0]       remaining, remaining_next;
    logic                done_next;

    // State and counters; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IM_CLEAR;
            clr_ptr   <= '0;
            wptr      <= '0;
            remaining <= '0;
            ld_done   <= 1'b0;
            ld_ready  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_next;
            clr_ptr   <= clr_ptr_next;
            wptr      <= wptr_next;
            remaining <= remaining_next;
            ld_done   <= done_next;
            ld_ready  <= (state_next == IM_LOAD);
            busy      <= (state_next != IM_IDLE);
        end
    end

    // Next-state, counter updates and write-port drive.
    always_comb begin
        state_next     = state;
        clr_ptr_next   = clr_ptr;
        wptr_next      = wptr;
        remaining_next = remaining;
        done_next      = 1'b0;
        wr_c           = '0;
        clearing_c     = (state == IM_CLEAR);

        case (state)
            IM_CLEAR: begin
                wr_c.en   = 1'b1;
                wr_c.addr = clr_ptr;
                wr_c.data = '0;
                if (clr_ptr == LAST_ADDR) begin
                    state_next   = IM_IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + PC_WIDTH'(1);
                end
            end
            IM_IDLE: begin
                if (clr_req) begin
                    state_next   = IM_CLEAR;
                    clr_ptr_next = '0;
                end else if (ld_start) begin
                    state_next     = IM_LOAD;
                    wptr_next      = ({1'b0, ld_base} >= DEPTH_EXT) ? '0 : ld_base;
                    remaining_next = ld_count;
                end
            end
            IM_LOAD: begin
                if (clr_req) begin
                    // Abort: no completion pulse, restart the walk from 0.
                    state_next   = IM_CLEAR;
                    clr_ptr_next = '0;
                end else if (remaining == '0) begin
                    state_next = IM_IDLE;
                    done_next  = 1'b1;
                end else if (ld_valid) begin
                    wr_c.en        = 1'b1;
                    wr_c.addr      = wptr;
                    wr_c.data      = ld_data;
                    wptr_next      = (wptr == LAST_ADDR) ? '0 : wptr + PC_WIDTH'(1);
                    remaining_next = remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        state_next = IM_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IM_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_ml.sv
// Multi-port instruction memory: one program store, PORTS independent read
// ports, a streaming loader and a word-per-cycle clear engine.
// Optional per-word even parity with a par_err output: INSTR_MEM_PARITY_EN.
module instr_mem_ml
    import instr_mem_ml_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned PORTS    = 2,
    parameter int unsigned REG_READ = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS*PC_WIDTH-1:0]    rd_addr,
    output logic [PORTS*INSTR_WIDTH-1:0] rd_data,
    input  logic                         clr_req,
    input  logic                         ld_start,
    input  logic [PC_WIDTH-1:0]          ld_base,
    input  logic [PC_WIDTH:0]            ld_count,
    input  logic                         ld_valid,
    input  logic [INSTR_WIDTH-1:0]       ld_data,
    output logic                         ld_ready,
    output logic                         ld_done,
    output logic                         busy
`ifdef INSTR_MEM_PARITY_EN
    ,
    output logic [PORTS-1:0]             par_err
`endif
);

    localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW        = PC_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_EXT = CW'(DEPTH);

    im_wr_t                       wr_c;
    logic                         clearing_c;
    logic [INSTR_WIDTH-1:0]       mem [DEPTH];
    logic [PORTS*INSTR_WIDTH-1:0] rd_data_c;
`ifdef INSTR_MEM_PARITY_EN
    logic                         par_mem [DEPTH];
    logic [PORTS-1:0]             par_err_c;
`endif

    instr_mem_loader #(
        .DEPTH(DEPTH)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_count   (ld_count),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .busy       (busy),
        .clearing_c (clearing_c),
        .wr_c       (wr_c)
    );

    // Single write port; contents are only ever zeroed by the clear walk.
    always_ff @(posedge clk) begin
        if (wr_c.en) begin
            mem[AW'(wr_c.addr)] <= wr_c.data;
`ifdef INSTR_MEM_PARITY_EN
            par_mem[AW'(wr_c.addr)] <= even_parity(wr_c.data);
`endif
        end
    end

    // Per-port read mux: zero while clearing or for out-of-range addresses.
    always_comb begin
        rd_data_c = '0;
`ifdef INSTR_MEM_PARITY_EN
        par_err_c = '0;
`endif
        for (int p = 0; p < PORTS; p++) begin
            if (!clearing_c && ({1'b0, rd_addr[p*PC_WIDTH +: PC_WIDTH]} < DEPTH_EXT)) begin
                rd_data_c[p*INSTR_WIDTH +: INSTR_WIDTH] = mem[AW'(rd_addr[p*PC_WIDTH +: PC_WIDTH])];
`ifdef INSTR_MEM_PARITY_EN
                par_err_c[p] = even_parity(mem[AW'(rd_addr[p*PC_WIDTH +: PC_WIDTH])])
                             ^ par_mem[AW'(rd_addr[p*PC_WIDTH +: PC_WIDTH])];
`endif
            end
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            // Registered read: samples the pre-write word, so read-before-write holds.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data <= '0;
`ifdef INSTR_MEM_PARITY_EN
                    par_err <= '0;
`endif
                end else begin
                    rd_data <= rd_data_c;
`ifdef INSTR_MEM_PARITY_EN
                    par_err <= par_err_c;
`endif
                end
            end
        end else begin : g_comb_read
            assign rd_data = rd_data_c;
`ifdef INSTR_MEM_PARITY_EN
            assign par_err = par_err_c;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_ml.sv
// Scoreboard bench for instr_mem_ml: a combinational-read and a
// registered-read instance share one stimulus stream.
module tb_instr_mem_ml;
    import instr_mem_ml_pkg::*;

    localparam int unsigned IW = INSTR_WIDTH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2*PC_WIDTH-1:0]   rd_addr;
    logic [2*IW-1:0]         rd_data0, rd_data1;
    logic                    clr_req, ld_start, ld_valid;
    logic [PC_WIDTH-1:0]     ld_base;
    logic [PC_WIDTH:0]       ld_count;
    logic [IW-1:0]           ld_data;
    logic                    ld_ready0, ld_ready1, ld_done0, ld_done1, busy0, busy1;
`ifdef INSTR_MEM_PARITY_EN
    logic [1:0]              par_err0, par_err1;
`endif

    always #5 clk = ~clk;

    instr_mem_ml #(.DEPTH(128), .PORTS(2), .REG_READ(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0),
        .clr_req(clr_req), .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0), .ld_done(ld_done0),
        .busy(busy0)
`ifdef INSTR_MEM_PARITY_EN
        , .par_err(par_err0)
`endif
    );

    instr_mem_ml #(.DEPTH(128), .PORTS(2), .REG_READ(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1),
        .clr_req(clr_req), .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1), .ld_done(ld_done1),
        .busy(busy1)
`ifdef INSTR_MEM_PARITY_EN
        , .par_err(par_err1)
`endif
    );

    typedef enum int {K_RD0, K_RD1, K_BUSY, K_READY} kind_e;
    typedef struct {
        int unsigned cyc;
        kind_e       kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        keep_q[$];
    int unsigned done_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_exp(input exp_t e);
        logic [31:0] act;
        logic [31:0] req;
        req = e.val;
        case (e.kind)
            K_RD0:   act = rd_data0[e.port*IW +: 32];
            K_RD1:   act = rd_data1[e.port*IW +: 32];
            K_BUSY:  begin act = {30'd0, busy1, busy0};         req = {30'd0, e.val[0], e.val[0]}; end
            default: begin act = {30'd0, ld_ready1, ld_ready0}; req = {30'd0, e.val[0], e.val[0]}; end
        endcase
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s port %0d cycle %0d: got %h, expected %h", e.kind.name(), e.port, e.cyc, act, req);
        end
    endtask

    // Monitor: compare queued expectations and ld_done pulses at mid-cycle.
    always @(negedge clk) begin
        keep_q.delete();
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == cyc) check_exp(exp_q[i]);
            else if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale %s cycle %0d: not compared", exp_q[i].kind.name(), exp_q[i].cyc);
            end else keep_q.push_back(exp_q[i]);
        end
        exp_q = keep_q;
        if (ld_done0 || ld_done1) begin
            checks++;
            if (done_q.size() != 0 && done_q[0] == cyc && ld_done0 && ld_done1) void'(done_q.pop_front());
            else begin
                errors++;
                $display("FAIL ld_done cycle %0d: got %b%b, expected pulse count pending %0d", cyc, ld_done1, ld_done0, done_q.size());
            end
        end
        if (done_q.size() != 0 && done_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL ld_done missing: got none, expected pulse at cycle %0d", done_q[0]);
            void'(done_q.pop_front());
        end
`ifdef INSTR_MEM_PARITY_EN
        checks++;
        if (par_err0 !== 2'b00 || par_err1 !== 2'b00) begin
            errors++;
            $display("FAIL par_err cycle %0d: got %b/%b, expected 00", cyc, par_err0, par_err1);
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input int unsigned c, input kind_e k, input int p, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.port = p; e.val = v;
        exp_q.push_back(e);
    endtask

    // Combinational port this cycle, registered port one cycle later.
    task automatic expect_rd(input int p, input logic [31:0] v);
        expect_at(cyc, K_RD0, p, v);
        expect_at(cyc + 1, K_RD1, p, v);
    endtask

    task automatic set_rd(input logic [PC_WIDTH-1:0] a0, input logic [PC_WIDTH-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic start_load(input logic [PC_WIDTH-1:0] base, input logic [PC_WIDTH:0] cnt);
        ld_start = 1'b1; ld_base = base; ld_count = cnt;
        tick();
        ld_start = 1'b0; ld_base = '0; ld_count = '0;
    endtask

    logic [31:0] words [4] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
    logic [6:0]  gap_pat = 7'b1001101;
    int unsigned c0, s, a, f;
    int          wi;

    initial begin
        rst = 1'b1; clr_req = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_base = '0; ld_count = '0; ld_data = '0; rd_addr = '0;
        tick(); tick();

        // Reset state
        expect_at(cyc, K_BUSY, 0, 1);
        expect_at(cyc, K_READY, 0, 0);
        expect_rd(0, 32'h0);
        rst = 1'b0;
        c0 = cyc;
        expect_at(c0 + 127, K_BUSY, 0, 1);
        expect_at(c0 + 128, K_BUSY, 0, 0);

        // ld_start during CLEAR is ignored
        wait_until(c0 + 10);
        ld_start = 1'b1; ld_base = '0; ld_count = 9'd3;
        set_rd(8'd10, 8'd127);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        tick();
        ld_start = 1'b0; ld_count = '0;
        expect_at(cyc, K_READY, 0, 0);
        wait_until(c0 + 128);
        expect_at(cyc, K_READY, 0, 0);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);

        // Burst wrapping 126,127,0,1 with gaps in ld_valid
        wait_until(c0 + 130);
        s = cyc;
        start_load(8'd126, 9'd4);
        expect_at(cyc, K_READY, 0, 1);
        expect_at(cyc, K_BUSY, 0, 1);
        done_q.push_back(s + 8);
        wi = 0;
        for (int k = 0; k < 7; k++) begin
            ld_valid = gap_pat[k];
            ld_data  = gap_pat[k] ? words[wi] : 32'hFFFF_FFFF;
            if (gap_pat[k]) wi++;
            tick();
        end
        ld_valid = 1'b0;
        expect_at(cyc, K_BUSY, 0, 0);
        expect_at(cyc, K_READY, 0, 0);
        set_rd(8'd126, 8'd127);
        expect_rd(0, 32'hA0A0_0001);
        expect_rd(1, 32'hB0B0_0002);
        tick();
        set_rd(8'd0, 8'd1);
        expect_rd(0, 32'hC0C0_0003);
        expect_rd(1, 32'hD0D0_0004);
        tick();
        set_rd(8'd2, 8'd125);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        tick();

        // Zero-length load: done pulse, no write even with ld_valid high
        s = cyc;
        start_load(8'd5, 9'd0);
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        expect_at(cyc, K_READY, 0, 1);
        expect_at(cyc, K_BUSY, 0, 1);
        done_q.push_back(s + 2);
        tick();
        ld_valid = 1'b0;
        expect_at(cyc, K_BUSY, 0, 0);
        set_rd(8'd5, 8'd5);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        tick();

        // Base >= DEPTH starts at 0; address >= DEPTH reads zero
        s = cyc;
        start_load(8'd200, 9'd1);
        ld_valid = 1'b1; ld_data = 32'h7777_0000;
        done_q.push_back(s + 2);
        tick();
        ld_valid = 1'b0;
        set_rd(8'd0, 8'd128);
        expect_rd(0, 32'h7777_0000);
        expect_rd(1, 32'h0);
        tick();
        set_rd(8'd1, 8'd255);
        expect_rd(0, 32'hD0D0_0004);
        expect_rd(1, 32'h0);
        tick();

        // Same-cycle read/write of address 5 returns the old word
        s = cyc;
        start_load(8'd5, 9'd1);
        ld_valid = 1'b1; ld_data = 32'h0000_ABCD;
        set_rd(8'd0, 8'd5);
        expect_rd(0, 32'h7777_0000);
        expect_rd(1, 32'h0);
        done_q.push_back(s + 2);
        tick();
        ld_valid = 1'b0;
        expect_rd(1, 32'h0000_ABCD);
        tick();

        // Abort after 2 of 5 words: no done, full clear follows
        a = cyc;
        start_load(8'd20, 9'd5);
        ld_valid = 1'b1; ld_data = 32'h1234_0001;
        tick();
        ld_data = 32'h1234_0002;
        tick();
        ld_valid = 1'b0; clr_req = 1'b1;
        set_rd(8'd20, 8'd21);
        expect_rd(0, 32'h1234_0001);
        expect_rd(1, 32'h1234_0002);
        expect_at(cyc, K_READY, 0, 1);
        tick();
        clr_req = 1'b0;
        expect_at(cyc, K_BUSY, 0, 1);
        expect_at(cyc, K_READY, 0, 0);
        set_rd(8'd126, 8'd20);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        expect_at(a + 131, K_BUSY, 0, 1);
        expect_at(a + 132, K_BUSY, 0, 0);
        wait_until(a + 133);
        set_rd(8'd20, 8'd126);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        tick();
        set_rd(8'd5, 8'd0);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        tick();

        // clr_req wins over simultaneous ld_start in IDLE
        f = cyc;
        clr_req = 1'b1;
        start_load(8'd0, 9'd2);
        clr_req = 1'b0;
        expect_at(cyc, K_BUSY, 0, 1);
        expect_at(cyc, K_READY, 0, 0);
        expect_at(f + 128, K_BUSY, 0, 1);
        expect_at(f + 129, K_BUSY, 0, 0);
        wait_until(f + 132);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
        end
        if (done_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL ld_done drain: got %0d pending, expected 0", done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
